// File: rtl/pre_emphasis_mc.sv
// pre_emphasis_mc
//   Multi-channel pre-emphasis filter y[n] = x[n] - alpha*x[n-1] on a
//   channel-interleaved stream. Each channel keeps its own history register.
//   Alpha and bypass are sampled only on a start-of-frame sample, so a frame
//   is always processed with a single configuration. The pipeline has two
//   stages: the multiply is registered in S1, and rounding and saturation are
//   registered in S2, which drives the outputs.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   cfg_alpha    unsigned Q1.(ALPHA_WIDTH-1) coefficient, taken on accepted in_sof
//   cfg_bypass   1: y = x, taken on accepted in_sof
//   in_valid     x_in is valid
//   in_ready     a sample can be accepted this cycle
//   in_sof       start of frame, qualified by in_valid & in_ready
//   x_in         signed input sample
//   out_valid    y_out is valid
//   out_ready    downstream accepts y_out
//   y_out        signed filtered sample
//   out_channel  channel tag of y_out
//   out_sof      y_out is the first sample of a frame
//   out_sat      y_out was clipped
module pre_emphasis_mc #(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int NUM_CHANNELS  = 2,
  parameter int ALPHA_WIDTH   = 16,
  parameter int DEFAULT_ALPHA = 31785,
  localparam int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ALPHA_WIDTH-1:0]         cfg_alpha,
  input  logic                           cfg_bypass,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sof,
  input  logic signed [SAMPLE_WIDTH-1:0] x_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [SAMPLE_WIDTH-1:0] y_out,
  output logic [CH_WIDTH-1:0]            out_channel,
  output logic                           out_sof,
  output logic                           out_sat
);

  // Product width: signed sample times alpha, with alpha zero-extended to signed.
  localparam int PW = SAMPLE_WIDTH + ALPHA_WIDTH + 1;
  // Difference width: two guard bits are enough for x - q when alpha < 2.
  localparam int DW = SAMPLE_WIDTH + 2;

  localparam logic signed [PW-1:0] ROUND_BIAS = PW'(2 ** (ALPHA_WIDTH - 2));
  localparam logic signed [DW-1:0] MAX_Y      = DW'((2 ** (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [DW-1:0] MIN_Y      = ~MAX_Y;

  // Per-channel history and frame configuration
  logic signed [SAMPLE_WIDTH-1:0] hist_q [NUM_CHANNELS];
  logic signed [SAMPLE_WIDTH-1:0] hist_d [NUM_CHANNELS];
  logic [CH_WIDTH-1:0]            cnt_q, cnt_d;
  logic [ALPHA_WIDTH-1:0]         alpha_q, alpha_d;
  logic                           bypass_q, bypass_d;

  // S1: registered product
  logic                           s1_valid_q, s1_valid_d;
  logic signed [SAMPLE_WIDTH-1:0] s1_x_q, s1_x_d;
  logic signed [PW-1:0]           s1_prod_q, s1_prod_d;
  logic [CH_WIDTH-1:0]            s1_ch_q, s1_ch_d;
  logic                           s1_sof_q, s1_sof_d;
  logic                           s1_bypass_q, s1_bypass_d;

  // S2: output register
  logic                           out_valid_q, out_valid_d;
  logic signed [SAMPLE_WIDTH-1:0] y_q, y_d;
  logic [CH_WIDTH-1:0]            out_ch_q, out_ch_d;
  logic                           out_sof_q, out_sof_d;
  logic                           out_sat_q, out_sat_d;

  // Combinational helpers
  logic                           advance;
  logic                           accept;
  logic [CH_WIDTH-1:0]            acc_ch;
  logic [ALPHA_WIDTH-1:0]         eff_alpha;
  logic                           eff_bypass;
  logic signed [SAMPLE_WIDTH-1:0] hist_sel;
  logic signed [PW-1:0]           hist_ext, alpha_ext, prod;
  logic signed [PW-1:0]           rounded_sum, shifted;
  logic signed [DW-1:0]           q_term, diff;

  // Input side: handshake, channel selection, history update and S1 load.
  // A start-of-frame sample uses the incoming config and a zero history
  // right away, so the first sample of every frame passes through unfiltered.
  always_comb begin
    advance    = ~(out_valid_q & ~out_ready);
    in_ready   = ~rst & advance;
    accept     = in_valid & in_ready;
    acc_ch     = in_sof ? '0 : cnt_q;
    eff_alpha  = in_sof ? cfg_alpha : alpha_q;
    eff_bypass = in_sof ? cfg_bypass : bypass_q;
    hist_sel   = in_sof ? '0 : hist_q[acc_ch];
    hist_ext   = PW'(hist_sel);
    alpha_ext  = PW'({1'b0, eff_alpha});
    prod       = hist_ext * alpha_ext;

    hist_d      = hist_q;
    cnt_d       = cnt_q;
    alpha_d     = alpha_q;
    bypass_d    = bypass_q;
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_prod_d   = s1_prod_q;
    s1_ch_d     = s1_ch_q;
    s1_sof_d    = s1_sof_q;
    s1_bypass_d = s1_bypass_q;

    if (accept) begin
      if (in_sof) begin
        alpha_d  = cfg_alpha;
        bypass_d = cfg_bypass;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          hist_d[i] = '0;
        end
      end
      // History always holds the raw input, even in bypass.
      hist_d[acc_ch] = x_in;
      cnt_d = (acc_ch == CH_WIDTH'(NUM_CHANNELS - 1)) ? '0 : acc_ch + CH_WIDTH'(1);
    end

    if (advance) begin
      s1_valid_d  = accept;
      s1_x_d      = x_in;
      s1_prod_d   = prod;
      s1_ch_d     = acc_ch;
      s1_sof_d    = in_sof;
      s1_bypass_d = eff_bypass;
    end
  end

  // Output side: round half up, arithmetic shift, subtract and saturate.
  always_comb begin
    rounded_sum = s1_prod_q + ROUND_BIAS;
    shifted     = rounded_sum >>> (ALPHA_WIDTH - 1);
    q_term      = DW'(shifted);
    diff        = DW'(s1_x_q) - q_term;

    out_valid_d = out_valid_q;
    y_d         = y_q;
    out_ch_d    = out_ch_q;
    out_sof_d   = out_sof_q;
    out_sat_d   = out_sat_q;

    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_ch_d  = s1_ch_q;
        out_sof_d = s1_sof_q;
        if (s1_bypass_q) begin
          y_d       = s1_x_q;
          out_sat_d = 1'b0;
        end else if (diff > MAX_Y) begin
          y_d       = MAX_Y[SAMPLE_WIDTH-1:0];
          out_sat_d = 1'b1;
        end else if (diff < MIN_Y) begin
          y_d       = MIN_Y[SAMPLE_WIDTH-1:0];
          out_sat_d = 1'b1;
        end else begin
          y_d       = diff[SAMPLE_WIDTH-1:0];
          out_sat_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        hist_q[i] <= '0;
      end
      cnt_q       <= '0;
      alpha_q     <= ALPHA_WIDTH'(DEFAULT_ALPHA);
      bypass_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_prod_q   <= '0;
      s1_ch_q     <= '0;
      s1_sof_q    <= 1'b0;
      s1_bypass_q <= 1'b0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      out_ch_q    <= '0;
      out_sof_q   <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      cnt_q       <= cnt_d;
      alpha_q     <= alpha_d;
      bypass_q    <= bypass_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_prod_q   <= s1_prod_d;
      s1_ch_q     <= s1_ch_d;
      s1_sof_q    <= s1_sof_d;
      s1_bypass_q <= s1_bypass_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      out_ch_q    <= out_ch_d;
      out_sof_q   <= out_sof_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign y_out       = y_q;
  assign out_channel = out_ch_q;
  assign out_sof     = out_sof_q;
  assign out_sat     = out_sat_q;

endmodule
